// File: rtl/pipeline_mem_ctrl.sv
// rtl/pipeline_mem_ctrl.sv - MEM-stage data-memory sequencer with pipeline freeze
//
// Purpose:
//   Sits between the EX/MEM register outputs, a variable-latency data memory
//   (req/ack handshake) and the MEM/WB register inputs. While an access is
//   outstanding it freezes PC, IF/ID, ID/EX and EX/MEM (stall_o) and forces
//   bubbles into MEM/WB (wb_bubble_o). Read data is captured on ack and
//   presented to MEM/WB as MD_o. An access with no ack for TIMEOUT_CYCLES
//   BUSY cycles is abandoned and raises a sticky err_o.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   MemRead_i, MemWrite_i   access request from EX/MEM (both high = write)
//   addr_i, wdata_i         effective address and store data
//   mem_req_o, mem_we_o     registered memory request and direction
//   mem_addr_o, mem_wdata_o latched address and store data
//   mem_ack_i, mem_rdata_i  one-cycle completion pulse and its read data
//   stall_o, wb_bubble_o    pipeline freeze and MEM/WB bubble
//   MD_o                    read data to MEM/WB
//   err_o                   sticky timeout flag
//
// Optional feature (macro MEM_CTRL_PERF_EN):
//   stall_cnt_o   saturating count of stalled cycles
//   access_cnt_o  saturating count of started accesses

module pipeline_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        wb_bubble_o,
  output logic [31:0] MD_o,
  output logic        err_o
`ifdef MEM_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] access_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Last counter value of a BUSY phase; the access has then spent
  // TIMEOUT_CYCLES cycles in BUSY.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        md_q, md_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic access_w;
  logic timeout_w;

  assign access_w  = MemRead_i | MemWrite_i;
  assign timeout_w = (cnt_q == TO_LAST);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      md_q      <= 32'd0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      md_q      <= md_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    md_d      = md_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (access_w) begin
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          // Read+write together is handled as a write, so MD is left alone.
          mem_we_d  = MemWrite_i;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack is checked first so a late ack on the timeout cycle still wins.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            md_d = mem_rdata_i;
          end
          state_d = DONE;
        end else if (timeout_w) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          md_d      = 32'd0;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Access inputs are ignored here so the completing instruction
        // cannot restart its own access as it leaves EX/MEM.
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Pipeline control outputs
  always_comb begin
    stall_o     = 1'b0;
    wb_bubble_o = 1'b0;
    case (state_q)
      IDLE: begin
        // Non-memory instructions see no added latency.
        stall_o     = access_w;
        wb_bubble_o = access_w;
      end
      BUSY: begin
        stall_o     = 1'b1;
        wb_bubble_o = 1'b1;
      end
      default: begin
        stall_o     = 1'b0;
        wb_bubble_o = 1'b0;
      end
    endcase
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign MD_o        = md_q;
  assign err_o       = err_q;

`ifdef MEM_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] access_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q  <= 32'd0;
      access_cnt_q <= 32'd0;
    end else begin
      if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((state_q == IDLE) && access_w && (access_cnt_q != 32'hFFFF_FFFF)) begin
        access_cnt_q <= access_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign access_cnt_o = access_cnt_q;
`endif

endmodule

// File: doc/pipeline_mem_ctrl.md
Name: pipeline_mem_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the 5-stage pipeline against a variable-latency memory with a req/ack handshake.
- While an access is outstanding, it freezes PC, IF/ID, ID/EX and EX/MEM.
- During the freeze, it forces bubbles into MEM/WB.
- It delivers the captured read data to MEM/WB as MD.
- It sits between the EX/MEM register outputs, the data memory, and the MEM/WB register inputs.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles before the access is abandoned (range 1..2^CNT_W-1)
CNT_W, 8, width of the timeout counter

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-low
MemRead_i  input  1  load in MEM stage (from EX/MEM)
MemWrite_i  input  1  store in MEM stage (from EX/MEM)
addr_i  input  32  ALU result / effective address
wdata_i  input  32  store data
mem_req_o  output  1  memory request, registered
mem_we_o  output  1  1 = write, registered
mem_addr_o  output  32  latched address
mem_wdata_o  output  32  latched store data
mem_ack_i  input  1  memory completion, one-cycle pulse
mem_rdata_i  input  32  read data, valid with mem_ack_i
stall_o  output  1  hold PC, IF/ID, ID/EX, EX/MEM
wb_bubble_o  output  1  force RegWrite=0 and MemtoReg=0 into MEM/WB
MD_o  output  32  read data to MEM/WB MD_i
err_o  output  1  sticky timeout flag

Behaviour:
- Reset (async, rst_i=0):
  - state=IDLE.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, MD_o=0, err_o=0, counter=0.
  - stall_o=0, wb_bubble_o=0.
  - Reset mid-access drops mem_req_o immediately. A later ack is ignored.
- States:
  - IDLE: stall_o = MemRead_i|MemWrite_i (combinational); wb_bubble_o = same.
    - On access: latch addr_i and wdata_i; mem_we_o <= MemWrite_i; mem_req_o <= 1; counter <= 0; go to BUSY.
    - MemRead_i and MemWrite_i both high: treated as a write; MD_o is not updated.
  - BUSY: stall_o=1, wb_bubble_o=1, mem_req_o held at 1 with stable address, data and we; counter increments each cycle.
    - mem_ack_i=1: mem_req_o <= 0; if read, MD_o <= mem_rdata_i; go to DONE.
    - counter reaches TIMEOUT_CYCLES-1 without ack: mem_req_o <= 0; err_o <= 1; MD_o <= 0; go to DONE.
    - If ack and timeout occur in the same cycle, ack wins and err_o is unchanged.
  - DONE: stall_o=0, wb_bubble_o=0. The access instruction advances into MEM/WB with MD_o at the next edge. Always go to IDLE. MemRead_i/MemWrite_i are ignored in DONE, so an access never restarts.
- Timing:
  - Minimum access latency: ack in the first BUSY cycle gives 2 stall cycles, then DONE.
  - Total stall = 1 (IDLE decision) + number of BUSY cycles.
- Signal rules:
  - mem_ack_i in IDLE or DONE is ignored.
  - MD_o holds its value outside read completion.
  - err_o clears only on reset.
- Non-memory instructions pass with zero added latency (stall_o=0 in IDLE).
- Back-to-back loads: the second load is seen in IDLE the cycle after DONE and starts a new access.

Optional Feature:
MEM_CTRL_PERF_EN
- Defined: adds outputs stall_cnt_o[31:0] and access_cnt_o[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - stall_cnt_o increments every cycle stall_o=1.
  - access_cnt_o increments on each IDLE->BUSY transition.
- Undefined: the ports and counters do not exist.

Test Plan:
- Load, addr_i=32'h10, ack after 3 BUSY cycles with rdata=32'hCAFEBABE -> stall_o high 4 cycles, wb_bubble_o high 4 cycles, then DONE with MD_o=32'hCAFEBABE, mem_req_o low.
- Store, addr=32'h20, wdata=32'h55; ack in first BUSY cycle -> mem_we_o=1, mem_wdata_o=32'h55, stall 2 cycles, MD_o unchanged.
- No memory op for 10 cycles, with spurious mem_ack_i pulses -> stall_o=0 throughout; no state change.
- TIMEOUT_CYCLES=4, load with no ack -> req drops after 4 BUSY cycles, err_o=1 (sticky), MD_o=0, pipeline released.
- Two consecutive loads (acks after 1 and 2 cycles) -> two distinct requests, stall 2 then 3 cycles, with a single non-stalled DONE cycle between them.
- rst_i pulsed low in BUSY, ack arrives after reset -> all outputs 0, ack ignored, IDLE; with MEM_CTRL_PERF_EN defined, the counters read 0.
